display_scan_n: RTL and testbench

//   Parametrised multiplexed 7-segment driver, successor to the fixed 4-digit scanner.
//   - Scans DIGITS hex digits, one digit at a time, for a fixed dwell period each.
//   - Adds per-digit decimal points, leading-zero blanking and PWM brightness.
//   - Latches inputs once per frame, so a digit never changes partway through a scan.
//   - Sits between the stopwatch/counter datapath and the board's anode/segment pins.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 17 +
 rtl/display_scan_n.sv | 140 ++++++++++++++
 tb/tb_display_scan_n.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table and constants for the display scanners.
package seg7_pkg;

  // All seven segments dark, in active-low form.
  localparam logic [6:0] SEG7_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyph for one hex nibble.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
    logic [6:0] glyph;
    case (hex)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to 7-segment pattern, in the polarity the board pins expect.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Look up the active-low glyph and flip it for active-high boards.
  always_comb begin
    seg = hex_to_seg7(nibble);
    if (ACTIVE_LOW == 0) seg = ~seg;
  end

endmodule

// File: rtl/display_scan_n.sv
// Parametrised multiplexed 7-segment scanner with per-digit decimal points,
// leading-zero blanking and PWM brightness. Inputs are captured once per frame.
module display_scan_n
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DWELL_LOG2 = 14,
  parameter int BRIGHT_W   = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digit,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     node,
  output logic [7:0]            segment,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] NODE_OFF = {DIGITS{ACTIVE_LOW != 0}};
  localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW != 0}};
  localparam logic [6:0]        GLYPH_OFF = (ACTIVE_LOW != 0) ? SEG7_OFF : ~SEG7_OFF;

  logic [DWELL_LOG2-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  started_q, started_d;
  logic [4*DIGITS-1:0]   digit_sh_q, digit_sh_d;
  logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
  logic [BRIGHT_W-1:0]   bright_sh_q, bright_sh_d;
  logic [DIGITS-1:0]     lz_mask_q, lz_mask_d;
  logic [DIGITS-1:0]     node_q, node_d;
  logic [7:0]            segment_q, segment_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  dwell_end;
  logic                  frame_end;
  logic                  shadow_load;
  logic                  upper_zero;
  logic [DIGITS-1:0]     lz_next;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [DIGITS-1:0]     node_on;
  logic                  lit;
  logic [6:0]            glyph;

  // Dwell and digit-index counters; a frame ends on the last dwell cycle of the top digit.
  always_comb begin
    dwell_end = &dwell_q;
    frame_end = dwell_end && (idx_q == IDX_LAST);
    dwell_d   = dwell_q + DWELL_LOG2'(1);
    idx_d     = idx_q;
    if (dwell_end) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    started_d = started_q | frame_end;
  end

  // Shadow copies of the inputs, refreshed at frame end and throughout reset.
  always_comb begin
    shadow_load = rst | frame_end;
    upper_zero  = 1'b1;
    lz_next     = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (digit[4*k +: 4] == 4'h0);
      lz_next[k] = blank_lz & upper_zero;
    end
    digit_sh_d  = shadow_load ? digit    : digit_sh_q;
    dp_sh_d     = shadow_load ? dp       : dp_sh_q;
    bright_sh_d = shadow_load ? bright   : bright_sh_q;
    lz_mask_d   = shadow_load ? lz_next  : lz_mask_q;
  end

  // Pick out the currently scanned digit and decide whether it is lit this cycle.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    node_on    = NODE_OFF;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nibble = digit_sh_q[4*k +: 4];
        cur_dp     = dp_sh_q[k];
        cur_lz     = lz_mask_q[k];
        node_on[k] = ~NODE_OFF[k];
      end
    end
    lit = !cur_lz && (dwell_q[DWELL_LOG2-1 -: BRIGHT_W] <= bright_sh_q);
  end

  seg7_decode #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decode (
    .nibble (cur_nibble),
    .seg    (glyph)
  );

  // Next node/segment pattern; both come from the same state so they change together.
  always_comb begin
    node_d       = lit ? node_on : NODE_OFF;
    segment_d    = SEG_OFF;
    if (lit) segment_d = {((ACTIVE_LOW != 0) ? ~cur_dp : cur_dp), glyph};
    else     segment_d = {SEG_OFF[7], GLYPH_OFF};
    frame_tick_d = started_q && (idx_q == '0) && (dwell_q == '0);
  end

  // Scan state and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q      <= '0;
      idx_q        <= '0;
      started_q    <= 1'b0;
      node_q       <= NODE_OFF;
      segment_q    <= SEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      dwell_q      <= dwell_d;
      idx_q        <= idx_d;
      started_q    <= started_d;
      node_q       <= node_d;
      segment_q    <= segment_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Shadow registers; their load condition already covers reset.
  always_ff @(posedge clk) begin
    digit_sh_q  <= digit_sh_d;
    dp_sh_q     <= dp_sh_d;
    bright_sh_q <= bright_sh_d;
    lz_mask_q   <= lz_mask_d;
  end

  assign node       = node_q;
  assign segment    = segment_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_n.sv
// Self-checking bench for display_scan_n: a frame-timing model checked every
// cycle, plus pinned literal expectations at hand-computed scan positions.
module tb_display_scan_n;

  localparam int DIGITS     = 4;
  localparam int DWELL_LOG2 = 4;
  localparam int BRIGHT_W   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digit = 16'h1234;
  logic [3:0]  dp = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [1:0]  bright = 2'd3;

  logic [3:0]  node_lo, node_hi;
  logic [7:0]  seg_lo, seg_hi;
  logic        tick_lo, tick_hi;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  display_scan_n #(
    .DIGITS(DIGITS), .DWELL_LOG2(DWELL_LOG2), .BRIGHT_W(BRIGHT_W), .ACTIVE_LOW(1)
  ) dut_lo (
    .clk(clk), .rst(rst), .digit(digit), .dp(dp), .blank_lz(blank_lz),
    .bright(bright), .node(node_lo), .segment(seg_lo), .frame_tick(tick_lo)
  );

  display_scan_n #(
    .DIGITS(DIGITS), .DWELL_LOG2(DWELL_LOG2), .BRIGHT_W(BRIGHT_W), .ACTIVE_LOW(0)
  ) dut_hi (
    .clk(clk), .rst(rst), .digit(digit), .dp(dp), .blank_lz(blank_lz),
    .bright(bright), .node(node_hi), .segment(seg_hi), .frame_tick(tick_hi)
  );

  // Full active-low codes for hex 0..F, bit 7 high.
  logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic b, input logic [1:0] br);
    digit    = d;
    dp       = p;
    blank_lz = b;
    bright   = br;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Literal expectation given in active-low terms; the active-high copy is its inverse.
  task automatic checkLiteral(input string name, input logic [3:0] n, input logic [7:0] s, input logic tk);
    checkOutput({name, " node"},    {4'h0, node_lo}, {4'h0, n});
    checkOutput({name, " seg"},     seg_lo,          s);
    checkOutput({name, " tick"},    {7'h0, tick_lo}, {7'h0, tk});
    checkOutput({name, " hi node"}, {4'h0, node_hi}, {4'h0, ~n});
    checkOutput({name, " hi seg"},  seg_hi,          ~s);
  endtask

  // Model: t counts scan cycles since reset; frames are 64 cycles, digits 16 cycles.
  int          t = 0;
  logic [15:0] sh_digit;
  logic [3:0]  sh_dp;
  logic [1:0]  sh_bright;
  logic        sh_blank;
  logic [3:0]  exp_node;
  logic [7:0]  exp_seg;
  logic        exp_tick;
  logic        exp_valid = 1'b0;

  always @(posedge clk) begin
    int m_idx;
    int m_dw;
    logic [3:0] m_nib;
    logic m_lz;
    logic m_lit;
    if (rst) begin
      exp_node  = 4'hF;
      exp_seg   = 8'hFF;
      exp_tick  = 1'b0;
      t         = 0;
      sh_digit  = digit;
      sh_dp     = dp;
      sh_bright = bright;
      sh_blank  = blank_lz;
      exp_valid = 1'b1;
    end else begin
      m_idx = (t / 16) % 4;
      m_dw  = t % 16;
      m_nib = sh_digit[4*m_idx +: 4];
      m_lz  = (m_idx > 0) && sh_blank && ((sh_digit >> (4*m_idx)) == 16'h0);
      m_lit = !m_lz && (m_dw < 4 * (int'(sh_bright) + 1));
      if (m_lit) begin
        exp_node = ~(4'b0001 << m_idx);
        exp_seg  = {~sh_dp[m_idx], glyph_tbl[m_nib][6:0]};
      end else begin
        exp_node = 4'hF;
        exp_seg  = 8'hFF;
      end
      exp_tick = (t % 64 == 0) && (t > 0);
      if (t % 64 == 63) begin
        sh_digit  = digit;
        sh_dp     = dp;
        sh_bright = bright;
        sh_blank  = blank_lz;
      end
      t++;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      checkOutput("model node",    {4'h0, node_lo}, {4'h0, exp_node});
      checkOutput("model seg",     seg_lo,          exp_seg);
      checkOutput("model tick",    {7'h0, tick_lo}, {7'h0, exp_tick});
      checkOutput("model hi node", {4'h0, node_hi}, {4'h0, ~exp_node});
      checkOutput("model hi seg",  seg_hi,          ~exp_seg);
      checkOutput("model hi tick", {7'h0, tick_hi}, {7'h0, exp_tick});
    end
  end

  typedef struct {
    logic [15:0] d;
    logic [3:0]  p;
    logic        b;
    logic [1:0]  br;
  } pattern_t;

  pattern_t extra [4] = '{
    '{16'h89AB, 4'b1001, 1'b0, 2'd3},
    '{16'hCDEF, 4'b0000, 1'b0, 2'd2},
    '{16'h0A00, 4'b0000, 1'b1, 2'd3},
    '{16'h0007, 4'b0100, 1'b1, 2'd1}
  };

  initial begin
    applyStimulus(16'h1234, 4'b0000, 1'b0, 2'd3);
    rst = 1'b1;
    waitCycles(3);
    checkLiteral("reset", 4'hF, 8'hFF, 1'b0);
    rst = 1'b0;

    // Plain scan of 1234 at full brightness.
    waitCycles(1);  checkLiteral("t0 d0",  4'b1110, 8'h99, 1'b0);
    waitCycles(16); checkLiteral("t16 d1", 4'b1101, 8'hB0, 1'b0);
    waitCycles(16); checkLiteral("t32 d2", 4'b1011, 8'hA4, 1'b0);
    waitCycles(16); checkLiteral("t48 d3", 4'b0111, 8'hF9, 1'b0);
    waitCycles(16); checkLiteral("t64 tick", 4'b1110, 8'h99, 1'b1);

    // Mid-frame input change waits for the next frame.
    waitCycles(16); applyStimulus(16'hFFFF, 4'b0000, 1'b0, 2'd3);
    waitCycles(16); checkLiteral("t96 held", 4'b1011, 8'hA4, 1'b0);
    waitCycles(32); checkLiteral("t128 new", 4'b1110, 8'h8E, 1'b1);
    applyStimulus(16'h0050, 4'b0000, 1'b1, 2'd3);

    // Leading-zero blanking.
    waitCycles(64); checkLiteral("lz d0",   4'b1110, 8'hC0, 1'b1);
    waitCycles(16); checkLiteral("lz d1",   4'b1101, 8'h92, 1'b0);
    waitCycles(16); checkLiteral("lz d2",   4'b1111, 8'hFF, 1'b0);
    applyStimulus(16'h0000, 4'b0000, 1'b1, 2'd3);
    waitCycles(32); checkLiteral("zero d0", 4'b1110, 8'hC0, 1'b1);
    waitCycles(16); checkLiteral("zero d1", 4'b1111, 8'hFF, 1'b0);
    applyStimulus(16'h1234, 4'b0000, 1'b0, 2'd1);

    // Brightness 1 then 0.
    waitCycles(48); checkLiteral("br1 dw0", 4'b1110, 8'h99, 1'b1);
    waitCycles(7);  checkLiteral("br1 dw7", 4'b1110, 8'h99, 1'b0);
    waitCycles(1);  checkLiteral("br1 dw8", 4'b1111, 8'hFF, 1'b0);
    applyStimulus(16'h1234, 4'b0000, 1'b0, 2'd0);
    waitCycles(56); checkLiteral("br0 dw0", 4'b1110, 8'h99, 1'b1);
    waitCycles(4);  checkLiteral("br0 dw4", 4'b1111, 8'hFF, 1'b0);
    applyStimulus(16'h0000, 4'b0010, 1'b0, 2'd3);

    // Decimal point on digit 1.
    waitCycles(60); checkLiteral("dp d0", 4'b1110, 8'hC0, 1'b1);
    waitCycles(16); checkLiteral("dp d1", 4'b1101, 8'h40, 1'b0);
    waitCycles(16); checkLiteral("dp d2", 4'b1011, 8'hC0, 1'b0);

    // One-cycle reset mid-frame.
    rst = 1'b1;
    waitCycles(1);  checkLiteral("midrst", 4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
    waitCycles(1);  checkLiteral("restart t0",  4'b1110, 8'hC0, 1'b0);
    waitCycles(15); checkLiteral("restart t15", 4'b1110, 8'hC0, 1'b0);
    waitCycles(1);  checkLiteral("restart t16", 4'b1101, 8'h40, 1'b0);

    // Remaining glyphs and blanking mixes, checked by the model.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(extra[i].d, extra[i].p, extra[i].b, extra[i].br);
      waitCycles(64);
    end
    waitCycles(130);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
